// File: rtl/div_issue_if.sv
// Bundle of the execute-side request/response ports and the divider-core ports of div_issue.
// Every valid/ready pair transfers on a rising clock edge where both are high; the sender holds its payload stable while valid is high and ready is low.
interface div_issue_if #(parameter int TAG_W = 5);
  logic             flush_i;
  logic             req_valid_i;
  logic             req_ready_o;
  logic [1:0]       req_op_i;
  logic [31:0]      req_a_i;
  logic [31:0]      req_b_i;
  logic [TAG_W-1:0] req_tag_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [31:0]      rsp_data_o;
  logic [TAG_W-1:0] rsp_tag_o;
  logic             div_valid_o;
  logic             div_ready_i;
  logic [31:0]      div_a_o;
  logic [31:0]      div_b_o;
  logic             div_done_i;
  logic             div_ack_o;
  logic [31:0]      div_q_i;
  logic [31:0]      div_r_i;

  modport slave (
    input  flush_i, req_valid_i, req_op_i, req_a_i, req_b_i, req_tag_i,
           rsp_ready_i, div_ready_i, div_done_i, div_q_i, div_r_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_tag_o,
           div_valid_o, div_a_o, div_b_o, div_ack_o
  );

  modport master (
    output flush_i, req_valid_i, req_op_i, req_a_i, req_b_i, req_tag_i,
           rsp_ready_i, div_ready_i, div_done_i, div_q_i, div_r_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_tag_o,
           div_valid_o, div_a_o, div_b_o, div_ack_o
  );
endinterface

// File: rtl/div_issue.sv
// RISC-V DIV/DIVU/REM/REMU front end: resolves special cases locally, issues magnitudes to the core, sign-corrects results.
// Optional macro DIV_FASTPATH_EN also answers |a| < |b| (which covers a == 0) locally.
module div_issue #(
  parameter int TAG_W = 5
) (
  input  logic       clock,
  input  logic       nreset,
  div_issue_if.slave bus,
  output logic [2:0] dbg_state
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t           state, state_nx;
  logic             req_ready_q;
  logic             is_rem_q;
  logic [TAG_W-1:0] tag_q;
  logic             neg_a_q, neg_b_q;
  logic [31:0]      mag_a_q, mag_b_q;
  logic [31:0]      rsp_data_q;

  logic             is_signed, neg_a, neg_b, accept, local_hit;
  logic [31:0]      mag_a, mag_b, local_data;
  logic [31:0]      q_fix, r_fix, core_data;

  // Request decode; flush wins over a same-cycle accept.
  always_comb begin
    is_signed  = ~bus.req_op_i[0];
    neg_a      = is_signed & bus.req_a_i[31];
    neg_b      = is_signed & bus.req_b_i[31];
    mag_a      = neg_a ? (32'd0 - bus.req_a_i) : bus.req_a_i;
    mag_b      = neg_b ? (32'd0 - bus.req_b_i) : bus.req_b_i;
    accept     = bus.req_valid_i & req_ready_q & ~bus.flush_i;
    local_hit  = 1'b0;
    local_data = 32'd0;
    if (bus.req_b_i == 32'd0) begin
      local_hit  = 1'b1;
      local_data = bus.req_op_i[1] ? bus.req_a_i : 32'hFFFF_FFFF;
    end else if (is_signed && bus.req_a_i == 32'h8000_0000 && bus.req_b_i == 32'hFFFF_FFFF) begin
      local_hit  = 1'b1;
      local_data = bus.req_op_i[1] ? 32'd0 : 32'h8000_0000;
    end
`ifdef DIV_FASTPATH_EN
    else if (mag_a < mag_b) begin
      local_hit  = 1'b1;
      local_data = bus.req_op_i[1] ? bus.req_a_i : 32'd0;
    end
`else
`endif
  end

  // Quotient sign follows a^b, remainder sign follows the dividend.
  always_comb begin
    q_fix     = (neg_a_q ^ neg_b_q) ? (32'd0 - bus.div_q_i) : bus.div_q_i;
    r_fix     = neg_a_q ? (32'd0 - bus.div_r_i) : bus.div_r_i;
    core_data = is_rem_q ? r_fix : q_fix;
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state       <= IDLE;
      req_ready_q <= 1'b0;
    end else begin
      state       <= state_nx;
      req_ready_q <= (state_nx == IDLE);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (accept) state_nx = local_hit ? RESP : ISSUE;
      ISSUE: begin
        if (bus.div_ready_i)  state_nx = bus.flush_i ? DRAIN : WAIT;
        else if (bus.flush_i) state_nx = IDLE;
      end
      // A flush that coincides with done has already consumed the result.
      WAIT: begin
        if (bus.flush_i)         state_nx = bus.div_done_i ? IDLE : DRAIN;
        else if (bus.div_done_i) state_nx = RESP;
      end
      DRAIN: if (bus.div_done_i) state_nx = IDLE;
      RESP:  if (bus.flush_i || bus.rsp_ready_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready_o = req_ready_q;
    bus.rsp_valid_o = (state == RESP);
    bus.div_valid_o = (state == ISSUE);
    bus.div_ack_o   = ((state == WAIT) || (state == DRAIN)) & bus.div_done_i;
    bus.div_a_o     = mag_a_q;
    bus.div_b_o     = mag_b_q;
    bus.rsp_data_o  = rsp_data_q;
    bus.rsp_tag_o   = tag_q;
    dbg_state       = state;
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      is_rem_q   <= 1'b0;
      tag_q      <= '0;
      neg_a_q    <= 1'b0;
      neg_b_q    <= 1'b0;
      mag_a_q    <= 32'd0;
      mag_b_q    <= 32'd0;
      rsp_data_q <= 32'd0;
    end else if (accept) begin
      is_rem_q <= bus.req_op_i[1];
      tag_q    <= bus.req_tag_i;
      neg_a_q  <= neg_a;
      neg_b_q  <= neg_b;
      mag_a_q  <= mag_a;
      mag_b_q  <= mag_b;
      if (local_hit) rsp_data_q <= local_data;
    end else if (state == WAIT && bus.div_done_i && !bus.flush_i) begin
      rsp_data_q <= core_data;
    end
  end
endmodule
